// File: rtl/spi_deserializer.sv
// Serial-to-parallel converter for the SPI receive path; MSB/LSB-first framing.
// Latency: p_data/p_valid update on the edge that samples the last bit of a word.
// Backpressure: none toward the serial side; an unaccepted word is overwritten and flags overrun.
//
// Ports:
//   clk, rst        : single clock, asynchronous active-high reset
//   enable, s_data  : bit strobe and serial bit
//   frame_sync      : synchronous restart, discards any partial word
//   msb_first       : bit order, latched on the first bit of each word
//   p_data, p_valid : held output word with valid/ready handshake (p_ready)
//   overrun         : sticky, cleared by ovr_clr
//   busy            : partial word in progress
module spi_deserializer #(
  parameter int bus_width   = 8,
  parameter int counter_reg = $clog2(bus_width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 s_data,
  input  logic                 frame_sync,
  input  logic                 msb_first,
  input  logic                 p_ready,
  input  logic                 ovr_clr,
  output logic [bus_width-1:0] p_data,
  output logic                 p_valid,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [counter_reg-1:0] last_cnt = counter_reg'(bus_width - 1);

  logic [bus_width-1:0]   sh;
  logic [counter_reg-1:0] cnt;
  logic                   mode;

  logic [bus_width-1:0]   base_sh;
  logic [counter_reg-1:0] base_cnt;
  logic [bus_width-1:0]   sh_next;
  logic [counter_reg-1:0] cnt_next;
  logic                   mode_next;
  logic                   done;
  logic                   ovr_evt;

  always_comb begin
    // frame_sync restarts the word in the same cycle, so a coincident
    // enable bit is treated as bit 0 against a cleared shift register.
    base_sh   = frame_sync ? '0 : sh;
    base_cnt  = frame_sync ? '0 : cnt;
    // The first bit of each word picks up the live msb_first; later bits
    // reuse the latched mode so a mid-word change cannot corrupt the word.
    mode_next = (enable && base_cnt == '0) ? msb_first : mode;
    sh_next   = base_sh;
    cnt_next  = base_cnt;
    done      = 1'b0;
    if (enable) begin
      if (mode_next) sh_next = {base_sh[bus_width-2:0], s_data};
      else           sh_next = {s_data, base_sh[bus_width-1:1]};
      if (base_cnt == last_cnt) begin
        done     = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = base_cnt + counter_reg'(1);
      end
    end
    ovr_evt = done && p_valid && !p_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      cnt     <= '0;
      mode    <= 1'b1;
      busy    <= 1'b0;
      p_data  <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sh   <= sh_next;
      cnt  <= cnt_next;
      mode <= mode_next;
      busy <= (cnt_next != '0);
      // A completion wins over an accept: the new word stays pending.
      if (done) begin
        p_data  <= sh_next;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
      // A new overrun event beats a coincident clear.
      overrun <= ovr_evt || (overrun && !ovr_clr);
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// Bench for spi_deserializer: directed scenarios plus random traffic against a
// word-level reference model; a second 16-bit instance covers the wide case.
module tb_spi_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, s_data = 1'b0, frame_sync = 1'b0;
  logic        msb_first = 1'b1, p_ready = 1'b0, ovr_clr = 1'b0;
  logic [7:0]  p_data;
  logic        p_valid, overrun, busy;

  logic        en16 = 1'b0, sd16 = 1'b0;
  logic [15:0] p_data16;
  logic        p_valid16, overrun16, busy16;
  logic        zero = 1'b0, one = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_deserializer #(.bus_width(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data),
    .frame_sync(frame_sync), .msb_first(msb_first), .p_ready(p_ready),
    .ovr_clr(ovr_clr), .p_data(p_data), .p_valid(p_valid),
    .overrun(overrun), .busy(busy)
  );

  spi_deserializer #(.bus_width(16)) dut16 (
    .clk(clk), .rst(rst), .enable(en16), .s_data(sd16),
    .frame_sync(zero), .msb_first(one), .p_ready(zero),
    .ovr_clr(zero), .p_data(p_data16), .p_valid(p_valid16),
    .overrun(overrun16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the partial word is a list of received bits; the word
  // value is assembled arithmetically once all 8 bits are in.
  int         bits[$];
  bit         m_mode;
  logic [7:0] m_data;
  bit         m_valid, m_ovr;

  task automatic model_reset();
    bits.delete();
    m_mode  = 1'b1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit sd, input bit fs,
                            input bit ms, input bit rdy, input bit clr);
    bit         complete = 1'b0;
    logic [7:0] w = 8'h00;
    bit         evt;
    if (fs) bits.delete();
    if (en) begin
      if (bits.size() == 0) m_mode = ms;
      bits.push_back(int'(sd));
      if (bits.size() == 8) begin
        complete = 1'b1;
        for (int i = 0; i < 8; i++)
          if (bits[i] != 0) w = w + (m_mode ? (8'd1 << (7 - i)) : (8'd1 << i));
        bits.delete();
      end
    end
    evt = complete && m_valid && !rdy;
    if (complete) begin
      m_data  = w;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_ovr = evt || (m_ovr && !clr);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".p_data"},  {24'h0, p_data}, {24'h0, m_data});
    check({tag, ".p_valid"}, {31'h0, p_valid}, {31'h0, m_valid});
    check({tag, ".overrun"}, {31'h0, overrun}, {31'h0, m_ovr});
    check({tag, ".busy"},    {31'h0, busy}, {31'h0, bits.size() != 0});
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled likewise.
  task automatic step(input string tag, input bit en, input bit sd, input bit fs,
                      input bit ms, input bit rdy, input bit clr);
    enable = en; s_data = sd; frame_sync = fs;
    msb_first = ms; p_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    model_edge(en, sd, fs, ms, rdy, clr);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input bit rdy, input bit clr);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b1, rdy, clr);
  endtask

  // Sends a stream of 8 bits, leftmost first; rdy applies only on the last bit.
  task automatic send8(input string tag, input logic [7:0] stream, input bit ms,
                       input bit rdy_last);
    logic [7:0] s;
    s = stream;
    for (int i = 0; i < 8; i++)
      step(tag, 1'b1, s[7 - i], 1'b0, ms, (i == 7) ? rdy_last : 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0]  s;
    logic [15:0] w16;
    model_reset();
    #12;
    rst = 1'b0;
    #2;
    compare_all("reset");
    check("reset.p_data", {24'h0, p_data}, 32'h0);

    // Scenario 1: MSB-first 0xC1, busy through bits 2..8
    s = 8'b1100_0001;
    for (int i = 0; i < 8; i++) begin
      step("msb", 1'b1, s[7 - i], 1'b0, 1'b1, 1'b0, 1'b0);
      if (i < 7) check("msb.busy_mid", {31'h0, busy}, 32'h1);
    end
    check("msb.data", {24'h0, p_data}, 32'hC1);
    check("msb.valid", {31'h0, p_valid}, 32'h1);
    check("msb.busy_end", {31'h0, busy}, 32'h0);
    idle("drain1", 1'b1, 1'b1);

    // Scenario 2: LSB-first with msb_first toggled after bit 3
    for (int i = 0; i < 8; i++)
      step("lsb", 1'b1, s[7 - i], 1'b0, (i >= 3), 1'b0, 1'b0);
    check("lsb.data", {24'h0, p_data}, 32'h83);
    idle("drain2", 1'b1, 1'b1);

    // Scenario 3: back-to-back words, overrun, clear, then accept on completion
    send8("b2b", 8'hC1, 1'b1, 1'b0);
    send8("b2b", 8'h5A, 1'b1, 1'b0);
    check("ovr.data", {24'h0, p_data}, 32'h5A);
    check("ovr.flag", {31'h0, overrun}, 32'h1);
    check("ovr.valid", {31'h0, p_valid}, 32'h1);
    idle("ovr_clr", 1'b0, 1'b1);
    check("ovr.cleared", {31'h0, overrun}, 32'h0);
    idle("drain3", 1'b1, 1'b0);
    send8("acc", 8'hC1, 1'b1, 1'b0);
    send8("acc", 8'h5A, 1'b1, 1'b1);
    check("acc.ovr", {31'h0, overrun}, 32'h0);
    check("acc.valid", {31'h0, p_valid}, 32'h1);
    check("acc.data", {24'h0, p_data}, 32'h5A);
    idle("drain4", 1'b1, 1'b1);

    // Scenario 4: frame_sync discards a 5-bit partial word
    for (int i = 0; i < 5; i++)
      step("fs_pre", 1'b1, (i % 2 == 0), 1'b0, 1'b1, 1'b0, 1'b0);
    s = 8'h3C;
    for (int i = 0; i < 8; i++)
      step("fs", 1'b1, s[7 - i], (i == 0), 1'b1, 1'b0, 1'b0);
    check("fs.data", {24'h0, p_data}, 32'h3C);
    idle("drain5", 1'b1, 1'b1);

    // Scenario 5: asynchronous reset between edges mid-word
    for (int i = 0; i < 4; i++)
      step("rst_pre", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst.p_data", {24'h0, p_data}, 32'h0);
    check("arst.p_valid", {31'h0, p_valid}, 32'h0);
    check("arst.overrun", {31'h0, overrun}, 32'h0);
    check("arst.busy", {31'h0, busy}, 32'h0);
    #1 rst = 1'b0;
    send8("post_rst", 8'hA5, 1'b1, 1'b0);
    check("post_rst.data", {24'h0, p_data}, 32'hA5);
    check("post_rst.valid", {31'h0, p_valid}, 32'h1);
    idle("drain6", 1'b1, 1'b1);

    // Scenario 6: 0xC1 with random enable gaps
    s = 8'hC1;
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++)
        step("stall_gap", 1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0);
      step("stall", 1'b1, s[7 - i], 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("stall.data", {24'h0, p_data}, 32'hC1);
    check("stall.valid", {31'h0, p_valid}, 32'h1);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++)
      step("rand", ($urandom_range(9, 0) < 7), 1'($urandom),
           ($urandom_range(29, 0) == 0), 1'($urandom),
           1'($urandom), ($urandom_range(9, 0) == 0));

    // 16-bit instance: MSB-first 0xBEEF
    enable = 1'b0;
    w16 = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      en16 = 1'b1;
      sd16 = w16[15 - i];
      @(posedge clk);
      #1;
      check("w16.busy", {31'h0, busy16}, (i < 15) ? 32'h1 : 32'h0);
      check("w16.valid", {31'h0, p_valid16}, (i < 15) ? 32'h0 : 32'h1);
    end
    en16 = 1'b0;
    check("w16.data", {16'h0, p_data16}, 32'hBEEF);
    check("w16.ovr", {31'h0, overrun16}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
